// File: rtl/wr_ptr_full.sv
// wr_ptr_full: write-side pointer and flag generator for an async FIFO,
// living entirely in the write clock domain.
//
// The FIFO depth is 2^(WIDTH-1). Both pointers carry one extra wrap bit so
// that full and empty can be told apart.
//
// Ports:
//   clk          write-domain clock
//   rst          asynchronous active-high reset
//   clr          synchronous clear (same targets as rst)
//   en           write request
//   rd_gray      read-side Gray pointer (asynchronous to clk)
//   wr_addr      RAM write address (low WIDTH-1 bits of cnt_bin)
//   cnt_bin      binary write pointer
//   cnt_gray     Gray write pointer, sent to the read domain
//   wr_level     registered fill level as seen from the write side
//   wr_ack       one-cycle pulse for each accepted write
//   almost_full  registered, level >= AF_LEVEL
//   full         registered full flag
//   overflow     sticky, write attempted while full
module wr_ptr_full #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] rd_gray,
  output logic [WIDTH-2:0] wr_addr,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic [WIDTH-1:0] wr_level,
  output logic             wr_ack,
  output logic             almost_full,
  output logic             full,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] AF_THR = WIDTH'(AF_LEVEL);

  logic [WIDTH-1:0] cnt_bin_q,  cnt_bin_d;
  logic [WIDTH-1:0] cnt_gray_q, cnt_gray_d;
  logic [WIDTH-1:0] wr_level_q, wr_level_d;
  logic             wr_ack_q,   wr_ack_d;
  logic             af_q,       af_d;
  logic             full_q,     full_d;
  logic             ovf_q,      ovf_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  logic             acc;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] rbin;
  logic [WIDTH-1:0] lvl_nxt;

  always_comb begin
    acc      = en & ~full_q;
    bin_nxt  = cnt_bin_q + WIDTH'(acc);
    gray_nxt = (bin_nxt >> 1) ^ bin_nxt;

    s = sync_q[SYNC_STAGES-1];
    // Gray-to-binary: bit i is the XOR of all Gray bits from i up to the MSB.
    rbin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rbin[i] = ^(s >> i);
    end

    lvl_nxt = bin_nxt - rbin;

    sync_d[0] = rd_gray;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    cnt_bin_d  = bin_nxt;
    cnt_gray_d = gray_nxt;
    // Full when the next write pointer equals the read pointer with the two
    // top Gray bits inverted (one full lap ahead).
    full_d     = (gray_nxt == {~s[WIDTH-1:WIDTH-2], s[WIDTH-3:0]});
    wr_level_d = lvl_nxt;
    af_d       = (lvl_nxt >= AF_THR);
    wr_ack_d   = acc;
    ovf_d      = ovf_q | (en & full_q);

    if (clr) begin
      cnt_bin_d  = '0;
      cnt_gray_d = '0;
      full_d     = 1'b0;
      wr_level_d = '0;
      af_d       = 1'b0;
      wr_ack_d   = 1'b0;
      ovf_d      = 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_bin_q  <= '0;
      cnt_gray_q <= '0;
      wr_level_q <= '0;
      wr_ack_q   <= 1'b0;
      af_q       <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      cnt_bin_q  <= cnt_bin_d;
      cnt_gray_q <= cnt_gray_d;
      wr_level_q <= wr_level_d;
      wr_ack_q   <= wr_ack_d;
      af_q       <= af_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wr_addr     = cnt_bin_q[WIDTH-2:0];
  assign cnt_bin     = cnt_bin_q;
  assign cnt_gray    = cnt_gray_q;
  assign wr_level    = wr_level_q;
  assign wr_ack      = wr_ack_q;
  assign almost_full = af_q;
  assign full        = full_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_full.sv
// tb_wr_ptr_full: directed bench for wr_ptr_full (WIDTH=4, SYNC_STAGES=2,
// AF_LEVEL=6). Fill/overflow/read-release uses a vector table; wrap, clear
// and async reset are hand-written sequences.
module tb_wr_ptr_full;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       en;
  logic [3:0] rd_gray;
  logic [2:0] wr_addr;
  logic [3:0] cnt_bin;
  logic [3:0] cnt_gray;
  logic [3:0] wr_level;
  logic       wr_ack;
  logic       almost_full;
  logic       full;
  logic       overflow;

  wr_ptr_full #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .AF_LEVEL   (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (en),
    .rd_gray    (rd_gray),
    .wr_addr    (wr_addr),
    .cnt_bin    (cnt_bin),
    .cnt_gray   (cnt_gray),
    .wr_level   (wr_level),
    .wr_ack     (wr_ack),
    .almost_full(almost_full),
    .full       (full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic [3:0] rd;
    logic [3:0] bin;
    logic [3:0] gray;
    logic [3:0] lvl;
    logic       ack;
    logic       af;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t vecs [13];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cnt_bin"},  32'(cnt_bin),  32'h0);
    chk({tag, " cnt_gray"}, 32'(cnt_gray), 32'h0);
    chk({tag, " wr_addr"},  32'(wr_addr),  32'h0);
    chk({tag, " wr_level"}, 32'(wr_level), 32'h0);
    chk({tag, " wr_ack"},   32'(wr_ack),   32'h0);
    chk({tag, " af"},       32'(almost_full), 32'h0);
    chk({tag, " full"},     32'(full),     32'h0);
    chk({tag, " overflow"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    logic [3:0] mbin;
    logic [3:0] prev_gray;
    logic [3:0] exp_lvl;
    logic       wrapped;

    //            clr   en    rd      bin    gray     lvl  ack af full ovf
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 4'd1, 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 4'd2, 4'b0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'd3, 4'b0010, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 4'd4, 4'b0110, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'd5, 4'b0111, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 4'd6, 4'b0101, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, 4'd7, 4'b0100, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'd8, 4'b1100, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 4'h2, 4'd8, 4'b1100, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 4'h2, 4'd8, 4'b1100, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 4'h2, 4'd8, 4'b1100, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'h2, 4'd9, 4'b1101, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; clr = 1'b0; en = 1'b0; rd_gray = 4'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");

    for (int i = 0; i < 13; i++) begin
      clr = vecs[i].clr; en = vecs[i].en; rd_gray = vecs[i].rd;
      tick();
      chk($sformatf("v%0d cnt_bin", i),  32'(cnt_bin),     32'(vecs[i].bin));
      chk($sformatf("v%0d cnt_gray", i), 32'(cnt_gray),    32'(vecs[i].gray));
      chk($sformatf("v%0d wr_addr", i),  32'(wr_addr),     32'(vecs[i].bin[2:0]));
      chk($sformatf("v%0d wr_level", i), 32'(wr_level),    32'(vecs[i].lvl));
      chk($sformatf("v%0d wr_ack", i),   32'(wr_ack),      32'(vecs[i].ack));
      chk($sformatf("v%0d af", i),       32'(almost_full), 32'(vecs[i].af));
      chk($sformatf("v%0d full", i),     32'(full),        32'(vecs[i].full));
      chk($sformatf("v%0d overflow", i), 32'(overflow),    32'(vecs[i].ovf));
    end

    // Advance the read pointer to 2 behind (bin 7) and let it settle.
    mbin = 4'd9;
    en = 1'b0; rd_gray = g(mbin - 4'd2);
    tick(); tick(); tick();
    chk("settle wr_level", 32'(wr_level), 32'd2);
    chk("settle full", 32'(full), 32'd0);

    // 20 writes with the read side tracking 2 entries behind.
    wrapped = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      prev_gray = cnt_gray;
      rd_gray = g(mbin - 4'd2);
      en = 1'b1;
      tick();
      mbin = mbin + 4'd1;
      if (mbin == 4'd0) wrapped = 1'b1;
      exp_lvl = (k == 1) ? 4'd3 : (k == 2) ? 4'd4 : 4'd5;
      chk($sformatf("wrap%0d cnt_bin", k),  32'(cnt_bin),  32'(mbin));
      chk($sformatf("wrap%0d cnt_gray", k), 32'(cnt_gray), 32'(g(mbin)));
      chk($sformatf("wrap%0d wr_addr", k),  32'(wr_addr),  32'(mbin[2:0]));
      chk($sformatf("wrap%0d gray_step", k), 32'($countones(cnt_gray ^ prev_gray)), 32'd1);
      chk($sformatf("wrap%0d wr_ack", k),   32'(wr_ack),   32'd1);
      chk($sformatf("wrap%0d full", k),     32'(full),     32'd0);
      chk($sformatf("wrap%0d wr_level", k), 32'(wr_level), 32'(exp_lvl));
    end
    chk("wrap seen", 32'(wrapped), 32'd1);
    chk("pre-clr overflow", 32'(overflow), 32'd1);

    // Synchronous clear wins over a concurrent write.
    clr = 1'b1; en = 1'b1;
    tick();
    chk_all_zero("clr");
    clr = 1'b0; en = 1'b1; rd_gray = 4'h0;
    tick(); tick(); tick();
    chk("post-clr cnt_bin", 32'(cnt_bin), 32'd3);
    chk("post-clr wr_level", 32'(wr_level), 32'd3);
    chk("post-clr overflow", 32'(overflow), 32'd0);

    // Asynchronous reset between edges clears outputs before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    #1;
    rst = 1'b0; en = 1'b0;
    tick();
    chk_all_zero("after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
